// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with tree-PLRU replacement,
// single-beat refill from the next level and a deferred fence.i flush.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req_valid/req_ready accepts a fetch; mem_req_valid/mem_req_ready issues a
// refill, and mem_req_valid/mem_req_addr stay stable until accepted.
// resp_valid and mem_resp_valid are single-cycle pulses with no back-pressure.
module icache_nway #(
   parameter int WAYS   = 4,
   parameter int SETS   = 128,
   parameter int TAG_W  = 21,
   parameter int LINE_W = 64,
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   fencei_flush,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [TAG_W-1:0]       req_tag,
   input  logic [IDX_W-1:0]       req_index,
   output logic                   resp_valid,
   output logic [LINE_W-1:0]      resp_data,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [TAG_W+IDX_W-1:0] mem_req_addr,
   input  logic                   mem_resp_valid,
   input  logic [LINE_W-1:0]      mem_resp_data,
   output logic [2:0]             fsm_state
);

   localparam int WAY_W = $clog2(WAYS);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      MISS_REQ  = 3'd2,
      MISS_WAIT = 3'd3,
      FLUSH     = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [WAYS-1:0]   valid    [SETS];
   logic [WAYS-2:0]   plru     [SETS];
   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [LINE_W-1:0] data_mem [SETS][WAYS];

   logic [TAG_W-1:0] r_tag;
   logic [IDX_W-1:0] r_index;
   logic             flush_pending;
   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] victim;
   logic             accept;
   logic             lookup_hit;
   logic             refill;

   // Tree nodes are heap-ordered: node n has children 2n+1 and 2n+2, and the
   // leaves WAYS-1 .. 2*WAYS-2 map to ways 0 .. WAYS-1. A node bit of 0 sends
   // the victim search to the lower half.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
      logic [2*WAYS-1:0] pad;
      logic [WAY_W:0]    node;
      pad  = {{(WAYS+1){1'b0}}, bits};
      node = '0;
      for (int l = 0; l < WAY_W; l++)
         node = {node[WAY_W-1:0], 1'b0} + {{WAY_W{1'b0}}, 1'b1} + {{WAY_W{1'b0}}, pad[node]};
      // leaf index minus (WAYS-1) is the low WAY_W bits of leaf+1
      node = node + {{WAY_W{1'b0}}, 1'b1};
      return node[WAY_W-1:0];
   endfunction

   // Walk the path of an accessed way and make every node point away from it.
   function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                  input logic [WAY_W-1:0] way);
      logic [2*WAYS-1:0] pad;
      logic [WAY_W:0]    node;
      logic [WAY_W-1:0]  w;
      logic              dir;
      pad  = {{(WAYS+1){1'b0}}, bits};
      node = '0;
      w    = way;
      for (int l = 0; l < WAY_W; l++) begin
         dir       = w[WAY_W-1];
         w         = w << 1;
         pad[node] = ~dir;
         node      = {node[WAY_W-1:0], 1'b0} + {{WAY_W{1'b0}}, 1'b1} + {{WAY_W{1'b0}}, dir};
      end
      return pad[WAYS-2:0];
   endfunction

   assign accept     = req_valid && req_ready;
   assign lookup_hit = (state == LOOKUP) && hit;
   assign refill     = (state == MISS_WAIT) && mem_resp_valid;
   assign mem_req_addr = {r_tag, r_index};
   assign fsm_state  = state;

   // Tag compare across all ways of the registered set.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[r_index][w] && (tag_mem[r_index][w] == r_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Victim: lowest-numbered invalid way, otherwise the PLRU choice.
   always_comb begin
      victim = plru_victim(plru[r_index]);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[r_index][w])
            victim = WAY_W'(w);
      end
   end

   // State register, request capture and flush bookkeeping; a new flush pulse
   // wins over the clear so a pulse landing in FLUSH stays pending.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         flush_pending <= 1'b0;
         r_tag         <= '0;
         r_index       <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            r_tag   <= req_tag;
            r_index <= req_index;
         end
         if (fencei_flush)
            flush_pending <= 1'b1;
         else if (state == FLUSH)
            flush_pending <= 1'b0;
      end
   end

   // Valid and PLRU bits: cleared by reset or FLUSH, updated on hit or refill.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            plru[s]  <= '0;
         end
      end else if (state == FLUSH) begin
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            plru[s]  <= '0;
         end
      end else begin
         if (lookup_hit)
            plru[r_index] <= plru_touch(plru[r_index], hit_way);
         if (refill) begin
            valid[r_index][victim] <= 1'b1;
            plru[r_index]          <= plru_touch(plru[r_index], victim);
         end
      end
   end

   // Tag and data arrays; contents are only trusted behind a valid bit.
   always_ff @(posedge clk) begin
      if (refill) begin
         tag_mem[r_index][victim]  <= r_tag;
         data_mem[r_index][victim] <= mem_resp_data;
      end
   end

   // Next state and handshake outputs; a pending or arriving flush blocks
   // new requests and takes the IDLE exit first.
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_data     = mem_resp_data;
      mem_req_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !flush_pending && !fencei_flush;
            if (flush_pending || fencei_flush)
               state_nxt = FLUSH;
            else if (req_valid)
               state_nxt = LOOKUP;
         end
         LOOKUP: begin
            if (hit) begin
               resp_valid = 1'b1;
               resp_data  = data_mem[r_index][hit_way];
               state_nxt  = IDLE;
            end else begin
               state_nxt  = MISS_REQ;
            end
         end
         MISS_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready)
               state_nxt = MISS_WAIT;
         end
         MISS_WAIT: begin
            if (mem_resp_valid) begin
               resp_valid = 1'b1;
               resp_data  = mem_resp_data;
               state_nxt  = IDLE;
            end
         end
         FLUSH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (WAYS=4, SETS=128): expected response lines
// go into exp_q when a request is driven and are popped by the response
// monitor; control outputs are checked in place by the driver task.
module tb_icache_nway;

   localparam int WAYS   = 4;
   localparam int SETS   = 128;
   localparam int TAG_W  = 21;
   localparam int LINE_W = 64;
   localparam int IDX_W  = 7;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_MISS_WAIT = 3'd3;
   localparam logic [2:0] S_FLUSH     = 3'd4;

   logic                   clk = 1'b0;
   logic                   rstn = 1'b0;
   logic                   fencei_flush = 1'b0;
   logic                   req_valid = 1'b0;
   logic                   req_ready;
   logic [TAG_W-1:0]       req_tag = '0;
   logic [IDX_W-1:0]       req_index = '0;
   logic                   resp_valid;
   logic [LINE_W-1:0]      resp_data;
   logic                   mem_req_valid;
   logic                   mem_req_ready = 1'b0;
   logic [TAG_W+IDX_W-1:0] mem_req_addr;
   logic                   mem_resp_valid = 1'b0;
   logic [LINE_W-1:0]      mem_resp_data = '0;
   logic [2:0]             fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [LINE_W-1:0] exp_q[$];
   logic [LINE_W-1:0] model[int unsigned];

   // clock / reset
   always #5 clk = ~clk;

   icache_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rstn(rstn), .fencei_flush(fencei_flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_tag(req_tag), .req_index(req_index),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .fsm_state(fsm_state)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] line_of(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
      return {8'hC0, 3'b000, t, 1'b0, i, 24'h5A5A5A};
   endfunction

   // scoreboard: every response pulse must match the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (resp_valid === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
               n_fail++;
               $error("FAIL resp_unexpected: observed resp_valid=1 expected no response");
            end
            if (exp_q.size() > 0)
               chk("resp_data", resp_data, exp_q.pop_front());
         end
      end
   end

   // driver: one fetch; on a miss, optionally stall the refill request and
   // optionally pulse fence.i while the refill is outstanding
   task automatic do_req(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                         input logic exp_hit, input logic [LINE_W-1:0] fill,
                         input int stall, input logic flush_in_wait);
      int unsigned key;
      int          cnt;
      key = {4'h0, tag, idx};
      @(negedge clk);
      cnt = 0;
      while (req_ready !== 1'b1 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("req_ready_before_req", req_ready, 1'b1);
      req_valid = 1'b1;
      req_tag   = tag;
      req_index = idx;
      if (exp_hit)
         exp_q.push_back(model[key]);
      else
         exp_q.push_back(fill);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (exp_hit) begin
         chk("hit_resp_valid", resp_valid, 1'b1);
         chk("hit_no_mem_req", mem_req_valid, 1'b0);
      end else begin
         chk("miss_resp_valid", resp_valid, 1'b0);
         @(negedge clk);
         #1;
         for (int i = 0; i < stall; i++) begin
            chk("stall_mem_req_valid", mem_req_valid, 1'b1);
            chk("stall_mem_req_addr", mem_req_addr, {tag, idx});
            chk("stall_req_ready", req_ready, 1'b0);
            @(negedge clk);
            #1;
         end
         chk("mem_req_valid", mem_req_valid, 1'b1);
         chk("mem_req_addr", mem_req_addr, {tag, idx});
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         if (flush_in_wait)
            fencei_flush = 1'b1;
         #1;
         chk("wait_no_mem_req", mem_req_valid, 1'b0);
         chk("wait_no_resp", resp_valid, 1'b0);
         @(negedge clk);
         fencei_flush   = 1'b0;
         mem_resp_valid = 1'b1;
         mem_resp_data  = fill;
         #1;
         chk("refill_resp_valid", resp_valid, 1'b1);
         @(negedge clk);
         mem_resp_valid = 1'b0;
         model[key] = fill;
      end
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset values while rstn is low
      repeat (3) @(negedge clk);
      #1;
      chk("reset_state", fsm_state, S_IDLE);
      chk("reset_resp_valid", resp_valid, 1'b0);
      chk("reset_mem_req_valid", mem_req_valid, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("ready_after_reset", req_ready, 1'b1);

      // cold miss, then hit on the same line
      do_req(21'h12, 7'd5, 1'b0, 64'h0000_0000_DEAD_BEEF, 0, 1'b0);
      do_req(21'h12, 7'd5, 1'b1, '0, 0, 1'b0);

      // fill set 7 with tags 1..4 (ways 0..3); hitting 3,2,1 in that order
      // leaves the tree pointing at the way holding tag 4
      for (int t = 1; t <= 4; t++)
         do_req(TAG_W'(t), 7'd7, 1'b0, line_of(TAG_W'(t), 7'd7), 0, 1'b0);
      do_req(21'd3, 7'd7, 1'b1, '0, 0, 1'b0);
      do_req(21'd2, 7'd7, 1'b1, '0, 0, 1'b0);
      do_req(21'd1, 7'd7, 1'b1, '0, 0, 1'b0);
      do_req(21'd5, 7'd7, 1'b0, line_of(21'd5, 7'd7), 0, 1'b0);
      do_req(21'd1, 7'd7, 1'b1, '0, 0, 1'b0);
      do_req(21'd2, 7'd7, 1'b1, '0, 0, 1'b0);
      do_req(21'd3, 7'd7, 1'b1, '0, 0, 1'b0);
      do_req(21'd5, 7'd7, 1'b1, '0, 0, 1'b0);
      do_req(21'd4, 7'd7, 1'b0, line_of(21'd4, 7'd7), 0, 1'b0);

      // refill request held off for 10 cycles
      do_req(21'h1ABCD, 7'd99, 1'b0, line_of(21'h1ABCD, 7'd99), 10, 1'b0);

      // fence.i during MISS_WAIT: refill responds, then one FLUSH cycle
      do_req(21'h77, 7'd20, 1'b0, line_of(21'h77, 7'd20), 0, 1'b1);
      #1;
      chk("flush_pending_blocks_ready", req_ready, 1'b0);
      chk("flush_pending_idle", fsm_state, S_IDLE);
      @(negedge clk);
      #1;
      chk("flush_state", fsm_state, S_FLUSH);
      chk("flush_req_ready", req_ready, 1'b0);
      @(negedge clk);
      #1;
      chk("post_flush_ready", req_ready, 1'b1);
      do_req(21'h12, 7'd5, 1'b0, 64'h1111_2222_3333_4444, 0, 1'b0);
      do_req(21'h12, 7'd5, 1'b1, '0, 0, 1'b0);

      // request and flush in the same IDLE cycle
      @(negedge clk);
      req_valid    = 1'b1;
      req_tag      = 21'h12;
      req_index    = 7'd5;
      fencei_flush = 1'b1;
      #1;
      chk("flush_vs_req_ready", req_ready, 1'b0);
      @(negedge clk);
      fencei_flush = 1'b0;
      req_valid    = 1'b0;
      #1;
      chk("flush_vs_req_state", fsm_state, S_FLUSH);
      @(negedge clk);
      #1;
      chk("flush_vs_req_ready_after", req_ready, 1'b1);
      do_req(21'h12, 7'd5, 1'b0, 64'h5555_6666_7777_8888, 0, 1'b0);

      // reset in MISS_WAIT abandons the refill
      @(negedge clk);
      req_valid = 1'b1;
      req_tag   = 21'h33;
      req_index = 7'd9;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("abandon_miss", resp_valid, 1'b0);
      @(negedge clk);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1;
      chk("abandon_in_wait", fsm_state, S_MISS_WAIT);
      rstn = 1'b0;
      #1;
      chk("async_reset_state", fsm_state, S_IDLE);
      chk("async_reset_resp", resp_valid, 1'b0);
      chk("async_reset_mem_req", mem_req_valid, 1'b0);
      @(negedge clk);
      rstn           = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      #1;
      chk("stray_mem_resp", resp_valid, 1'b0);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      do_req(21'h12, 7'd5, 1'b0, 64'h9999_AAAA_BBBB_CCCC, 0, 1'b0);
      do_req(21'd5, 7'd7, 1'b0, line_of(21'd5, 7'd7), 0, 1'b0);
      do_req(21'h33, 7'd9, 1'b0, line_of(21'h33, 7'd9), 0, 1'b0);

      // every expected response must have been seen
      repeat (2) @(negedge clk);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
